// File: rtl/bus_rr_router.sv
// rtl/bus_rr_router.sv - round-robin/fixed-priority FIFO arbiter and destination router
// Optional BUS_LOOPBACK_EN: a packet addressed to its own source is delivered back instead of dropped.
module bus_rr_router #(
    parameter int          drvrs     = 5,
    parameter int          pckg_sz   = 16,
    parameter logic [7:0]  broadcast = 8'hFF,
    parameter int          ARB_MODE  = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [drvrs-1:0]               pndng,
    input  logic [drvrs-1:0][pckg_sz-1:0]  D_pop,
    input  logic [drvrs-1:0]               full,
    output logic [drvrs-1:0]               pop,
    output logic [drvrs-1:0]               push,
    output logic [drvrs-1:0][pckg_sz-1:0]  D_push,
    output logic                           busy,
    output logic [15:0]                    err_cnt
);

    localparam int SW = (drvrs > 1) ? $clog2(drvrs) : 1;
    localparam logic [drvrs-1:0] ONE = drvrs'(1);

    typedef enum logic [1:0] {IDLE, POP, ROUTE, PUSH} state_t;

    state_t                          state_q, state_d;
    logic [pckg_sz-1:0]              data_q, data_d;
    logic [SW-1:0]                   src_q, src_d;
    logic [SW-1:0]                   ptr_q, ptr_d;
    logic                            bcast_q, bcast_d;
    logic                            valid_q, valid_d;
    logic                            self_q, self_d;
    logic [drvrs-1:0]                mask_q, mask_d;
    logic [15:0]                     err_cnt_q, err_cnt_d;
    logic [drvrs-1:0]                pop_q, pop_d;
    logic [drvrs-1:0]                push_q, push_d;
    logic [drvrs-1:0][pckg_sz-1:0]   d_push_q, d_push_d;
    logic                            busy_q, busy_d;

    logic [SW-1:0]                   win;
    logic [SW:0]                     cand;
    logic [7:0]                      dest;
    logic                            drop;

    assign dest = data_q[pckg_sz-1 -: 8];

`ifdef BUS_LOOPBACK_EN
    assign drop = !bcast_q && !valid_q;
`else
    assign drop = !bcast_q && (!valid_q || self_q);
`endif

    // Scan far-to-near so the candidate closest after the pointer is the last one kept.
    always_comb begin
        win  = '0;
        cand = '0;
        if (ARB_MODE == 1) begin
            for (int k = drvrs - 1; k >= 0; k--) begin
                if (pndng[k]) win = SW'(k);
            end
        end else begin
            for (int k = drvrs; k >= 1; k--) begin
                cand = {1'b0, ptr_q} + (SW+1)'(k);
                if (cand >= (SW+1)'(drvrs)) cand = cand - (SW+1)'(drvrs);
                if (pndng[cand[SW-1:0]]) win = cand[SW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            data_q    <= '0;
            src_q     <= '0;
            ptr_q     <= SW'(drvrs - 1);
            bcast_q   <= 1'b0;
            valid_q   <= 1'b0;
            self_q    <= 1'b0;
            mask_q    <= '0;
            err_cnt_q <= '0;
            pop_q     <= '0;
            push_q    <= '0;
            d_push_q  <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            src_q     <= src_d;
            ptr_q     <= ptr_d;
            bcast_q   <= bcast_d;
            valid_q   <= valid_d;
            self_q    <= self_d;
            mask_q    <= mask_d;
            err_cnt_q <= err_cnt_d;
            pop_q     <= pop_d;
            push_q    <= push_d;
            d_push_q  <= d_push_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|pndng) state_d = POP;
            POP:     state_d = ROUTE;
            ROUTE:   state_d = drop ? IDLE : PUSH;
            PUSH:    if ((mask_q & full) == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_d    = data_q;
        src_d     = src_q;
        ptr_d     = ptr_q;
        bcast_d   = bcast_q;
        valid_d   = valid_q;
        self_d    = self_q;
        mask_d    = mask_q;
        err_cnt_d = err_cnt_q;
        pop_d     = '0;
        push_d    = '0;
        d_push_d  = d_push_q;
        busy_d    = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (|pndng) begin
                    data_d = D_pop[win];
                    src_d  = win;
                    pop_d  = ONE << win;
                end
            end
            POP: begin
                bcast_d = (dest == broadcast);
                valid_d = (dest < 8'(drvrs));
                self_d  = (dest == 8'(src_q));
                ptr_d   = src_q;
            end
            ROUTE: begin
                // Broadcast never includes the source, even with loopback enabled.
                mask_d = bcast_q ? ~(ONE << src_q) : (ONE << dest[SW-1:0]);
                if (drop && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
            end
            PUSH: begin
                if ((mask_q & full) == '0) begin
                    push_d   = mask_q;
                    d_push_d = {drvrs{data_q}};
                end
            end
            default: ;
        endcase
    end

    assign pop     = pop_q;
    assign push    = push_q;
    assign D_push  = d_push_q;
    assign busy    = busy_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_bus_rr_router.sv
// tb/tb_bus_rr_router.sv - directed self-checking bench for bus_rr_router (drvrs=5, pckg_sz=16)
module tb_bus_rr_router;

    logic              clk = 1'b0;
    logic              reset;
    logic [4:0]        pndng;
    logic [4:0][15:0]  D_pop;
    logic [4:0]        full;
    logic [4:0]        pop, push, pop_fp, push_fp;
    logic [4:0][15:0]  D_push, dpush_fp;
    logic              busy, busy_fp;
    logic [15:0]       err_cnt, err_fp;

    int n_assert = 0;
    int n_fail   = 0;
    bit log_en   = 1'b0;
    int pop_log[$];
    int fp_log[$];
    logic [4:0]  pm;
    logic [79:0] pd;

    always #5 clk = ~clk;

    bus_rr_router #(.drvrs(5), .pckg_sz(16), .broadcast(8'hFF), .ARB_MODE(0)) dut (
        .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .full(full),
        .pop(pop), .push(push), .D_push(D_push), .busy(busy), .err_cnt(err_cnt)
    );

    bus_rr_router #(.drvrs(5), .pckg_sz(16), .broadcast(8'hFF), .ARB_MODE(1)) dut_fp (
        .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .full(full),
        .pop(pop_fp), .push(push_fp), .D_push(dpush_fp), .busy(busy_fp), .err_cnt(err_fp)
    );

    always @(negedge clk) begin
        if (log_en) begin
            for (int k = 0; k < 5; k++) begin
                if (pop[k])    pop_log.push_back(k);
                if (pop_fp[k]) fp_log.push_back(k);
            end
        end
    end

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        pndng = '0;
        full  = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 30; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        check(tag, 80'(busy), 80'(0));
    endtask

    task automatic run_pkt(input int s, input logic [15:0] w, output logic [4:0] m, output logic [79:0] d);
        m = '0;
        d = '0;
        @(negedge clk);
        pndng[s] = 1'b1;
        D_pop[s] = w;
        @(negedge clk);
        pndng[s] = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (push != '0) begin
                m = push;
                d = D_push;
            end
            if (!busy) break;
            @(negedge clk);
        end
        check("pkt_done", 80'(busy), 80'(0));
    endtask

    initial begin
        reset = 1'b1;
        pndng = '0;
        D_pop = '0;
        full  = '0;
        repeat (2) @(negedge clk);
        check("rst_pop",    80'(pop),     80'(0));
        check("rst_push",   80'(push),    80'(0));
        check("rst_dpush",  D_push,       80'(0));
        check("rst_busy",   80'(busy),    80'(0));
        check("rst_errcnt", 80'(err_cnt), 80'(0));
        reset = 1'b0;

        // unicast src 2 -> dst 3
        @(negedge clk);
        pndng[2] = 1'b1;
        D_pop[2] = 16'h03A5;
        @(negedge clk);
        pndng = '0;
        check("uni_pop",  80'(pop),  80'(5'b00100));
        check("uni_busy", 80'(busy), 80'(1));
        @(negedge clk);
        check("uni_pop_clr", 80'(pop), 80'(0));
        @(negedge clk);
        check("uni_push_early", 80'(push), 80'(0));
        @(negedge clk);
        check("uni_push",      80'(push),      80'(5'b01000));
        check("uni_data",      80'(D_push[3]), 80'(16'h03A5));
        check("uni_busy_done", 80'(busy),      80'(0));
        @(negedge clk);
        check("uni_push_clr", 80'(push),    80'(0));
        check("uni_errcnt",   80'(err_cnt), 80'(0));

        // round-robin vs fixed priority, all FIFOs pending, every packet to device 0
        do_reset();
        for (int i = 0; i < 5; i++) D_pop[i] = 16'(i);
        pop_log.delete();
        fp_log.delete();
        log_en = 1'b1;
        @(negedge clk);
        pndng = 5'b11111;
        repeat (40) @(negedge clk);
        pndng = '0;
        repeat (10) @(negedge clk);
        log_en = 1'b0;
        check("rr_len", 80'(pop_log.size() >= 6), 80'(1));
        check("fp_len", 80'(fp_log.size() >= 6),  80'(1));
        if (pop_log.size() >= 6 && fp_log.size() >= 6) begin
            for (int i = 0; i < 6; i++) begin
                check($sformatf("rr_order%0d", i), 80'(pop_log[i]), 80'(i % 5));
                check($sformatf("fp_order%0d", i), 80'(fp_log[i]),  80'(0));
            end
        end

        // broadcast from src 1 stalled by full[4]
        do_reset();
        full[4] = 1'b1;
        @(negedge clk);
        pndng[1] = 1'b1;
        D_pop[1] = 16'hFF42;
        @(negedge clk);
        pndng = '0;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("bc_stall%0d", i), 80'({push, busy}), 80'({5'b00000, 1'b1}));
            @(negedge clk);
        end
        full[4] = 1'b0;
        @(negedge clk);
        check("bc_push",  80'(push), 80'(5'b11101));
        check("bc_data",  D_push,    {5{16'hFF42}});
        check("bc_busy",  80'(busy), 80'(0));
        @(negedge clk);
        check("bc_push_clr", 80'(push),    80'(0));
        check("bc_errcnt",   80'(err_cnt), 80'(0));

        // invalid destination, then self-addressed
        run_pkt(0, 16'h0742, pm, pd);
        check("inv_push",   80'(pm),      80'(0));
        check("inv_errcnt", 80'(err_cnt), 80'(1));
        run_pkt(2, 16'h0211, pm, pd);
`ifdef BUS_LOOPBACK_EN
        check("self_push",   80'(pm),      80'(5'b00100));
        check("self_data",   pd,           {5{16'h0211}});
        check("self_errcnt", 80'(err_cnt), 80'(1));
`else
        check("self_push",   80'(pm),      80'(0));
        check("self_errcnt", 80'(err_cnt), 80'(2));
`endif

        // asynchronous reset while stalled in PUSH
        full[3] = 1'b1;
        @(negedge clk);
        pndng[2] = 1'b1;
        D_pop[2] = 16'h0311;
        @(negedge clk);
        pndng = '0;
        repeat (4) @(negedge clk);
        check("mid_busy", 80'(busy), 80'(1));
        reset = 1'b1;
        #1;
        check("mid_rst_push", 80'(push),    80'(0));
        check("mid_rst_pop",  80'(pop),     80'(0));
        check("mid_rst_busy", 80'(busy),    80'(0));
        check("mid_rst_err",  80'(err_cnt), 80'(0));
        @(negedge clk);
        reset = 1'b0;
        full  = '0;
        pndng = 5'b11111;
        @(negedge clk);
        pndng = '0;
        check("mid_first_pop", 80'(pop), 80'(5'b00001));
        wait_idle("mid_idle");

        // error counter saturation
        @(negedge clk);
        force dut.err_cnt_q = 16'hFFFE;
        #1;
        release dut.err_cnt_q;
        run_pkt(1, 16'h09AA, pm, pd);
        check("sat_first",  80'(err_cnt), 80'(16'hFFFF));
        check("sat_nopush", 80'(pm),      80'(0));
        run_pkt(1, 16'h09AA, pm, pd);
        check("sat_hold",   80'(err_cnt), 80'(16'hFFFF));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_rr_router.md
Name: bus_rr_router

Overview:
- Parametrised successor to the single-bus generator/arbiter. Arbitrates among `drvrs` device-side FIFOs with round-robin or fixed-priority selection.
- Pops one packet at a time from the winning FIFO and routes it by destination ID to one target device, or to all other devices on broadcast.
- Respects per-destination `full` backpressure, counts undeliverable packets, and is verified with the team's existing driver/agent/checker/scoreboard environment.

Parameters:
- drvrs, 5, number of attached devices (2..16).
- pckg_sz, 16, packet width in bits; must be >= 9.
- broadcast, 8'hFF, destination ID that means "deliver to all devices except the source".
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pndng  in  [drvrs-1:0]  device FIFO i holds at least one packet.
- D_pop  in  [drvrs-1:0][pckg_sz-1:0]  head word of FIFO i, first-word-fall-through, valid while pndng[i]=1.
- full  in  [drvrs-1:0]  receive FIFO of device i cannot accept a push.
- pop  out  [drvrs-1:0]  one-cycle pop strobe to FIFO i.
- push  out  [drvrs-1:0]  one-cycle push strobe into device i.
- D_push  out  [drvrs-1:0][pckg_sz-1:0]  data presented to device i; all lanes carry the same word.
- busy  out  1  high in any state other than IDLE.
- err_cnt  out  16  saturating count of dropped packets.

Behaviour:
- Packet format: destination ID = D_pop[pckg_sz-1 -: 8]; the remaining bits are payload.
- Reset (asynchronous, takes effect immediately, including mid-transfer):
  - pop=0, push=0, D_push=0, busy=0, err_cnt=0, state=IDLE.
  - Round-robin pointer = drvrs-1, so device 0 is favoured first.
  - Any packet in flight is discarded.
  - A FIFO already popped loses that packet; this is accepted.
- All outputs are registered.
- FSM states: IDLE, POP, ROUTE, PUSH.
- IDLE:
  - If pndng=0, stay in IDLE.
  - Otherwise select winner w:
    - ARB_MODE=0: first set pndng bit scanning upward from pointer+1 modulo drvrs.
    - ARB_MODE=1: lowest set index.
  - Latch data=D_pop[w] and src=w; go to POP.
- POP:
  - Assert pop[src] for exactly this cycle.
  - Decode destination: broadcast, or valid if ID < drvrs.
  - Round-robin pointer <= src.
  - Go to ROUTE.
- ROUTE:
  - Compute target mask:
    - Broadcast: all devices except src.
    - Valid ID: one-hot(ID).
  - Invalid ID (>= drvrs and not broadcast): err_cnt++ (saturating at 16'hFFFF), return to IDLE, no push.
  - Self-destination (ID == src): treated as invalid, unless BUS_LOOPBACK_EN is defined.
  - Otherwise go to PUSH.
- PUSH:
  - Stall while (mask & full) != 0; push stays 0 and D_push holds.
  - When clear: push=mask for one cycle and D_push[i]=data on every lane; return to IDLE.
  - Broadcast is all-or-nothing: no partial delivery.
- Minimum latency: 4 cycles from winner sampled in IDLE to push high; back-to-back packets every 4 cycles.
- pndng changes during POP, ROUTE or PUSH do not affect the current packet.
- A newly asserted pndng during PUSH is arbitrated in the next IDLE.
- drvrs=2 broadcast: exactly one target.

Optional Feature:
- Macro BUS_LOOPBACK_EN.
- Defined: destination ID == src is a valid unicast back to the source device; the broadcast mask still excludes the source.
- Undefined: self-addressed packets are dropped and counted in err_cnt.

Test Plan:
- Unicast: pndng[2]=1, D_pop[2]=16'h03A5 -> pop[2] pulse, then push=5'b01000 with D_push[3]=16'h03A5 four cycles after IDLE sample; err_cnt=0.
- Round-robin: pndng=5'b11111 held, each packet addressed to device 0 with full=0 -> pop order 0,1,2,3,4,0; with ARB_MODE=1 -> pop[0] every grant.
- Broadcast with backpressure: src 1 sends 16'hFF42 while full[4]=1 for 10 cycles -> push stays 0 and busy=1; after full[4] drops, push=5'b11101 for one cycle with all lanes 16'hFF42.
- Invalid/self: destination 8'h07 -> no push, err_cnt=1; self-addressed packet -> err_cnt=2 without the macro, or push[src] with BUS_LOOPBACK_EN.
- Reset mid-PUSH (stalled on full): assert reset -> push, pop and busy go 0 immediately; after release, device 0 wins first.
- err_cnt saturation: force 65537 invalid packets -> err_cnt holds 16'hFFFF.
